// File: rtl/color_issue_arbiter.sv
// rtl/color_issue_arbiter.sv - round-robin issue arbiter with per-color and shared in-flight admission
module color_issue_arbiter #(
    parameter int COLORS    = 4,
    parameter int MIN_DEPTH = 32,
    parameter int MAX_DEPTH = 512,
    parameter int HEAD_ROOM = MAX_DEPTH - COLORS * MIN_DEPTH,
    localparam int TW       = $clog2(COLORS),
    localparam int CW       = $clog2(MAX_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [COLORS-1:0] req,
    output logic [COLORS-1:0] grant,
    output logic              out_valid,
    output logic [TW-1:0]     out_tag,
    input  logic              out_ready,
    input  logic              retire,
    input  logic [TW-1:0]     retire_tag,
    output logic [CW-1:0]     total,
    output logic              err_underflow
);

    localparam logic [CW-1:0] L_MIN  = CW'(MIN_DEPTH);
    localparam logic [CW-1:0] L_HEAD = CW'(HEAD_ROOM);
    localparam logic [CW-1:0] L_MAX  = CW'(MAX_DEPTH);

    logic [CW-1:0]     r_count [COLORS];
    logic [CW-1:0]     r_total;
    logic [TW-1:0]     r_ptr;
    logic              r_out_valid;
    logic [TW-1:0]     r_out_tag;
    logic              r_err;

    logic [COLORS-1:0] w_elig;
    logic [TW-1:0]     w_winner;
    logic [TW-1:0]     w_idx;
    logic              w_any;
    logic              w_load;
    logic              w_ret_ok;

    always_comb begin
        for (int i = 0; i < COLORS; i++) begin
            w_elig[i] = req[i] && ((r_count[i] < L_MIN) || (r_total < L_HEAD)) && (r_total < L_MAX);
        end
    end

    // Scan from the farthest offset down so the nearest eligible index from r_ptr wins.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        w_idx    = '0;
        for (int k = COLORS - 1; k >= 0; k--) begin
            w_idx = r_ptr + TW'(k);
            if (w_elig[w_idx]) begin
                w_winner = w_idx;
                w_any    = 1'b1;
            end
        end
    end

    assign w_load   = enable && (!r_out_valid || out_ready) && w_any;
    assign w_ret_ok = retire && (r_count[retire_tag] != '0);

    always_comb begin
        grant = '0;
        if (w_load && rst_n) begin
            grant[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_ptr       <= '0;
            r_total     <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < COLORS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_tag   <= w_winner;
                r_ptr       <= w_winner + TW'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // An issue and a valid retire on the same color cancel out.
            for (int i = 0; i < COLORS; i++) begin
                if (w_load && (w_winner == TW'(i)) && !(w_ret_ok && (retire_tag == TW'(i)))) begin
                    r_count[i] <= r_count[i] + CW'(1);
                end else if (!(w_load && (w_winner == TW'(i))) && w_ret_ok && (retire_tag == TW'(i))) begin
                    r_count[i] <= r_count[i] - CW'(1);
                end
            end

            if (w_load && !w_ret_ok) begin
                r_total <= r_total + CW'(1);
            end else if (!w_load && w_ret_ok) begin
                r_total <= r_total - CW'(1);
            end

            if (retire && !w_ret_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_tag       = r_out_tag;
    assign total         = r_total;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_color_issue_arbiter.sv
// tb/tb_color_issue_arbiter.sv - scoreboard bench for color_issue_arbiter
module tb_color_issue_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic [3:0] grant;
    logic       out_valid;
    logic [1:0] out_tag;
    logic       out_ready;
    logic       retire;
    logic [1:0] retire_tag;
    logic [3:0] total;
    logic       err_underflow;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_tag;

    always #5 clk = ~clk;

    color_issue_arbiter #(
        .COLORS    (4),
        .MIN_DEPTH (1),
        .MAX_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .req           (req),
        .grant         (grant),
        .out_valid     (out_valid),
        .out_tag       (out_tag),
        .out_ready     (out_ready),
        .retire        (retire),
        .retire_tag    (retire_tag),
        .total         (total),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic rdy, input logic ret,
                       input logic [1:0] rt, input logic [3:0] eg, input int et);
        @(posedge clk);
        #1;
        req        = r;
        out_ready  = rdy;
        retire     = ret;
        retire_tag = rt;
        @(negedge clk);
        chk("grant", grant, eg);
        chk("total", total, et);
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) exp_q.push_back(2'(i));
        end
    endtask

    // Monitor: every accepted issue must match the next expected tag.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL issue_tag: got tag %0d expected no issue at %0t", out_tag, $time);
            end else begin
                exp_tag = exp_q.pop_front();
                if (out_tag !== exp_tag) begin
                    n_bad++;
                    $display("FAIL issue_tag: got %0d expected %0d at %0t", out_tag, exp_tag, $time);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        req        = '0;
        out_ready  = 1'b0;
        retire     = 1'b0;
        retire_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_total", total, 0);
        chk("rst_err", err_underflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-stream with an issue held in the register
        cyc(4'b0100, 0, 0, 0, 4'b0100, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_total", total, 0);
        chk("mid_rst_err", err_underflow, 0);
        chk("mid_rst_grant", grant, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b0000;

        // Round robin over all four colors until each holds its guaranteed slot
        cyc(4'b1111, 1, 0, 0, 4'b0001, 0);
        cyc(4'b1111, 1, 0, 0, 4'b0010, 1);
        cyc(4'b1111, 1, 0, 0, 4'b0100, 2);
        cyc(4'b1111, 1, 0, 0, 4'b1000, 3);
        cyc(4'b1111, 1, 0, 0, 4'b0000, 4);
        cyc(4'b0000, 1, 1, 0, 4'b0000, 4);
        cyc(4'b0000, 1, 1, 1, 4'b0000, 3);
        cyc(4'b0000, 1, 1, 2, 4'b0000, 2);
        cyc(4'b0000, 1, 1, 3, 4'b0000, 1);

        // Single color consumes its slot plus the head-room pool
        cyc(4'b0001, 1, 0, 0, 4'b0001, 0);
        cyc(4'b0001, 1, 0, 0, 4'b0001, 1);
        cyc(4'b0001, 1, 0, 0, 4'b0001, 2);
        cyc(4'b0001, 1, 0, 0, 4'b0001, 3);
        cyc(4'b0001, 1, 0, 0, 4'b0000, 4);
        cyc(4'b0001, 1, 1, 0, 4'b0000, 4);
        cyc(4'b0001, 1, 0, 0, 4'b0001, 3);

        // Downstream stall for three cycles, then release
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0010, 0, 0, 0, 4'b0000, 4);
            chk("stall_valid", out_valid, 1);
            chk("stall_tag", out_tag, 0);
        end
        cyc(4'b0010, 1, 0, 0, 4'b0010, 4);

        // Same-cycle issue and retire
        cyc(4'b0100, 1, 0, 0, 4'b0100, 5);
        cyc(4'b0000, 1, 1, 0, 4'b0000, 6);
        cyc(4'b0000, 1, 1, 0, 4'b0000, 5);
        cyc(4'b0000, 1, 1, 0, 4'b0000, 4);
        cyc(4'b0100, 1, 1, 2, 4'b0100, 3);
        cyc(4'b1000, 1, 1, 1, 4'b1000, 3);
        cyc(4'b0000, 1, 0, 0, 4'b0000, 3);

        // Underflow is sticky and does not disturb counts or grants
        cyc(4'b0000, 1, 1, 2, 4'b0000, 3);
        chk("err_before", err_underflow, 0);
        cyc(4'b0000, 1, 1, 2, 4'b0000, 2);
        chk("err_still_clear", err_underflow, 0);
        cyc(4'b0100, 1, 0, 0, 4'b0100, 2);
        chk("err_set", err_underflow, 1);
        cyc(4'b0000, 1, 0, 0, 4'b0000, 3);
        chk("err_sticky", err_underflow, 1);
        cyc(4'b0000, 1, 0, 0, 4'b0000, 3);
        chk("err_sticky2", err_underflow, 1);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/color_issue_arbiter.md
# color_issue_arbiter

Round-robin issue arbiter that shares one downstream request port between `COLORS` requesters, each identified by a color tag. It tracks in-flight requests per color and in total, and grants a requester only when the admission policy allows it: a guaranteed `MIN_DEPTH` slots per color plus a shared head-room pool. It sits in front of the decoder's shared memory/request path and replaces ad-hoc per-tag ready polling with a single sequencing point.

## Interface
- `COLORS`, 4: number of requesters/tags; power of two, at least 2.
- `MIN_DEPTH`, 32: in-flight slots guaranteed to each color.
- `MAX_DEPTH`, 512: hard cap on total in-flight requests; power of two.
- `HEAD_ROOM`, `MAX_DEPTH - COLORS*MIN_DEPTH`: shared pool size; must be at least 0.
- Derived widths: `TW` = log2(`COLORS`); `CW` = log2(`MAX_DEPTH`)+1, so a count can hold `MAX_DEPTH`.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when 0, no new grants; retires are still processed.
- `req`  in  `COLORS`  per-requester request level.
- `grant`  out  `COLORS`  one-hot, combinational; high in the cycle requester i's request is accepted.
- `out_valid`  out  1  issue register holds a request.
- `out_tag`  out  `TW`  color of the issued request.
- `out_ready`  in  1  downstream accepts `out_valid`/`out_tag` this cycle.
- `retire`  in  1  one in-flight request completes.
- `retire_tag`  in  `TW`  color of the completing request.
- `total`  out  `CW`  current total in-flight count (registered).
- `err_underflow`  out  1  sticky; set when a retire targets a color whose count is 0.

## Operation
- State:
  - `count[i]` (`CW` bits) per color.
  - `total` (`CW` bits).
  - Round-robin pointer `ptr` (`TW` bits).
  - Issue register holding `out_valid` and `out_tag`.
  - `err_underflow`.
- Eligibility of color i, evaluated on registered state: `req[i]` AND (`count[i]` < `MIN_DEPTH` OR `total` < `HEAD_ROOM`) AND `total` < `MAX_DEPTH`.
- Load condition: `enable` AND (`out_valid`=0 OR `out_ready`=1) AND at least one color is eligible.
- Winner: the first eligible index found searching `ptr`, `ptr`+1, … modulo `COLORS`.
- On load:
  - `grant[winner]`=1.
  - Next cycle `out_valid`=1 and `out_tag`=winner.
  - `ptr` becomes winner+1 (wraps to 0 after `COLORS`-1).
  - `count[winner]` and `total` each increment by 1.
- No load but `out_ready`=1: `out_valid` clears and `ptr` is unchanged.
- Stall (`out_valid`=1 and `out_ready`=0): `out_tag` held stable, all `grant` bits are 0.
- Retire of tag t:
  - If `count[t]` > 0: `count[t]` and `total` each decrement by 1.
  - If `count[t]` = 0: no change to any count (saturate at 0), and `err_underflow` is set.
- Same cycle issue and retire:
  - Same color: `count` and `total` unchanged.
  - Different colors: one increments, the other decrements; `total` unchanged.
- `err_underflow` clears only on reset.
- The `MAX_DEPTH` check guarantees `total` never exceeds `MAX_DEPTH`; no wrap is possible.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `out_valid`=0, `out_tag`=0, `total`=0, all `count`=0, `ptr`=0, `err_underflow`=0.
  - `grant` is forced to 0 while `rst_n`=0.
- Reset mid-operation discards the issue register and all counts. In-flight retires arriving after reset are counted as underflows.
- `grant` has zero latency from `req`; the issued tag appears on `out_tag` one cycle later.
- Requesters must treat `grant` as consumption and update `req` by the next edge.
- A retire in cycle N affects eligibility from cycle N+1.
- An issue in cycle N counts toward eligibility from cycle N+1, so there is no double-booking of the last slot.
- Peak throughput: one grant per cycle while `out_ready`=1.

## Test plan
Bench parameters: `COLORS`=4, `MIN_DEPTH`=1, `MAX_DEPTH`=8, so `HEAD_ROOM`=4.
1. Assert reset mid-stream with `out_valid`=1 → `out_valid`, `total`, `err_underflow` and `grant` are 0 immediately; after release, the first grant goes to lowest-index requester 0.
2. `req`=4'b1111, `out_ready`=1, no retires → `grant` sequence 0001, 0010, 0100, 1000 and `out_tag` 0, 1, 2, 3 one cycle later each; then `total`=4 with each count=1, so no further grants.
3. `req`=4'b0001 only → 4 grants, then stop with `count[0]`=4 and `total`=4; a single retire of tag 0 → a grant reappears in the following cycle.
4. `out_valid`=1 with `out_ready`=0 held 3 cycles → `grant`=0 and `out_tag` stable all 3 cycles; releasing `out_ready` → a grant in the same cycle.
5. Issue to color 2 and retire tag 2 in the same cycle with `count[2]`=1 → `count[2]`=1 and `total` unchanged; retire tag 1 and issue tag 3 together → `total` unchanged.
6. Retire tag 2 while `count[2]`=0 → `err_underflow`=1 next cycle and stays 1; `total` unchanged; grants continue normally.
